// File: rtl/switch_debouncer_pkg.sv
// Shared types and widths for the slide-switch debouncer.
package switch_debouncer_pkg;

    localparam int SW_W = 3;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } swdb_state_t;

endpackage

// File: rtl/switch_debouncer_sync_chain.sv
// Multi-flop synchroniser for an asynchronous bus; every stage clears to 0 on reset.
module sync_chain #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the raw bus through the metastability chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and whole-word debounces the 3-bit slide-switch bus for the LED decoder.
// Build option SWDB_CHANGE_PULSE_EN: when defined, `changed` pulses for one cycle per commit.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [SW_W-1:0] switch_in,
    output logic [SW_W-1:0] switch,
    output logic            changed
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync_q;
    logic [SW_W-1:0]  switch_r;
    logic [SW_W-1:0]  cand_r;
    logic [CNT_W-1:0] cnt_r;
    swdb_state_t      state_r;
    logic             commit_s;

    sync_chain #(
        .WIDTH  (SW_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (switch_in),
        .q   (sync_q)
    );

    // Commit when the candidate has survived the full window; a low enable vetoes it.
    always_comb begin
        commit_s = 1'b0;
        if (!enable) begin
            commit_s = 1'b0;
        end else if (sync_q == switch_r) begin
            commit_s = 1'b0;
        end else if (state_r == STABLE) begin
            commit_s = (DEBOUNCE_CYCLES == 1);
        end else begin
            commit_s = (sync_q == cand_r) && (cnt_r == LAST_CNT);
        end
    end

    // Debounce FSM with settle counter and committed output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= STABLE;
            cand_r   <= '0;
            cnt_r    <= '0;
            switch_r <= '0;
        end else if (!enable) begin
            state_r <= STABLE;
            cnt_r   <= '0;
        end else if (commit_s) begin
            switch_r <= sync_q;
            state_r  <= STABLE;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                STABLE: begin
                    if (sync_q != switch_r) begin
                        cand_r  <= sync_q;
                        cnt_r   <= CNT_W'(1);
                        state_r <= SETTLE;
                    end else begin
                        state_r <= STABLE;
                    end
                end
                SETTLE: begin
                    if (sync_q == switch_r) begin
                        state_r <= STABLE;
                        cnt_r   <= '0;
                    end else if (sync_q != cand_r) begin
                        cand_r <= sync_q;
                        cnt_r  <= CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= STABLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign switch = switch_r;

`ifdef SWDB_CHANGE_PULSE_EN
    logic changed_r;

    // One-cycle strobe following each commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_r <= 1'b0;
        end else begin
            changed_r <= commit_s;
        end
    end

    assign changed = changed_r;
`else
    assign changed = 1'b0;
`endif

endmodule
